// File: rtl/fifo_pop_reader.sv
// Purpose: pops words from fifo_top while it reports pending data and streams them downstream in order.
// Latency: pop issued in the cycle pnding is seen; the word is captured one edge later and shows as m_valid_o one edge after that.
// Backpressure: a 2-entry output buffer with credit-gated pops; a stalled sink stops popping once buffered + in-flight words reach 2.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   enable_i              level enable; low moves RUN -> DRAIN
//   fifo_pnding_i         fifo_top non-empty flag
//   fifo_data_i           fifo_top read data, valid the cycle after a pop
//   fifo_pop_o            one-cycle pop strobe to fifo_top
//   m_valid_o/m_ready_i   downstream handshake; m_data_o is the buffer head
//   idle_o                high while in IDLE
//   pop_cnt_o             words popped since reset, wraps at 2^CNT_W

module fifo_pop_reader #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              fifo_pnding_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_pop_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic              idle_o,
  output logic [CNT_W-1:0]  pop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q [2];

  logic              deq;
  logic [2:0]        committed;
  logic              credit_ok;

  assign deq       = m_valid_o & m_ready_i;

  // Words already owed to the buffer: those held plus the one arriving this
  // cycle. A new pop lands one edge from now, after this cycle's capture and
  // dequeue, so it is allowed while the committed count leaves a free slot.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit_ok = (committed <= (3'd1 + {2'b00, deq}));

  assign fifo_pop_o = (state_q == ST_RUN) & fifo_pnding_i & credit_ok;
  assign m_valid_o  = (occ_q != 2'd0);
  assign m_data_o   = buf_q[rd_q];
  assign idle_o     = (state_q == ST_IDLE);
  assign pop_cnt_o  = cnt_q;

  // Next-state: FSM and datapath bookkeeping.
  always_comb begin
    state_d    = state_q;
    inflight_d = fifo_pop_o;
    // Capture and dequeue in the same cycle cancel out.
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, deq};
    rd_d       = deq ? ~rd_q : rd_q;
    wr_d       = inflight_q ? ~wr_q : wr_q;
    cnt_d      = fifo_pop_o ? (cnt_q + CNT_W'(1)) : cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A pop issued in this last RUN cycle still completes: inflight
        // keeps DRAIN from finishing until its word is delivered.
        if (!enable_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Buffer storage: the word popped last cycle is on fifo_data_i now.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (inflight_q) begin
      buf_q[wr_q] <= fifo_data_i;
    end
  end

endmodule
